// File: rtl/range_pkg.sv
// Shared types for the range_finder_stats streaming min/max/range tracker.
package range_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_NO_GO  = 2'b01,
        ERR_GO_RUN = 2'b10,
        ERR_GO_FIN = 2'b11
    } err_t;

endpackage

// File: rtl/minmax_unit.sv
// Combinational min/max update of a running extreme pair with one new sample,
// comparing either as unsigned or two's-complement.
module minmax_unit #(
    parameter int unsigned WIDTH = 10
) (
    input  logic [WIDTH-1:0] cur_min,
    input  logic [WIDTH-1:0] cur_max,
    input  logic [WIDTH-1:0] sample,
    input  logic             signed_mode,
    output logic [WIDTH-1:0] new_min,
    output logic [WIDTH-1:0] new_max
);

    logic lt_min;
    logic gt_max;

    always_comb begin
        lt_min = 1'b0;
        gt_max = 1'b0;
        if (signed_mode) begin
            lt_min = $signed(sample) < $signed(cur_min);
            gt_max = $signed(sample) > $signed(cur_max);
        end else begin
            lt_min = sample < cur_min;
            gt_max = sample > cur_max;
        end
    end

    assign new_min = lt_min ? sample : cur_min;
    assign new_max = gt_max ? sample : cur_max;

endmodule

// File: rtl/range_finder_stats.sv
// Burst min/max/range/count tracker framed by go/finish, with a one-cycle
// result strobe and a sticky first-error code.
module range_finder_stats
    import range_pkg::*;
#(
    parameter int unsigned WIDTH     = 10,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 go,
    input  logic                 finish,
    input  logic                 signed_mode,
    output logic [WIDTH-1:0]     range,
    output logic [WIDTH-1:0]     min_out,
    output logic [WIDTH-1:0]     max_out,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 count_sat,
    output logic                 valid,
    output logic                 busy,
    output logic                 error,
    output logic [1:0]           err_code
);

    state_t               state_q;
    logic [WIDTH-1:0]     acc_min_q, acc_max_q;
    logic [CNT_WIDTH-1:0] acc_cnt_q;
    logic                 sat_q;
    logic                 mode_q;
    logic [WIDTH-1:0]     range_q, min_q, max_q;
    logic [CNT_WIDTH-1:0] count_q;
    logic                 count_sat_q;
    logic                 valid_q;
    logic                 error_q;
    err_t                 err_code_q;

    logic [WIDTH-1:0]     upd_min, upd_max;
    logic                 cnt_full;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 sat_d;

    minmax_unit #(.WIDTH(WIDTH)) u_minmax (
        .cur_min     (acc_min_q),
        .cur_max     (acc_max_q),
        .sample      (data_in),
        .signed_mode (mode_q),
        .new_min     (upd_min),
        .new_max     (upd_max)
    );

    // Saturating sample counter; sat records any increment attempted at full scale.
    assign cnt_full = (acc_cnt_q == '1);
    assign cnt_d    = cnt_full ? acc_cnt_q : acc_cnt_q + CNT_WIDTH'(1);
    assign sat_d    = sat_q | cnt_full;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_min_q   <= '0;
            acc_max_q   <= '0;
            acc_cnt_q   <= '0;
            sat_q       <= 1'b0;
            mode_q      <= 1'b0;
            range_q     <= '0;
            min_q       <= '0;
            max_q       <= '0;
            count_q     <= '0;
            count_sat_q <= 1'b0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go && !finish) begin
                        state_q    <= RUN;
                        acc_min_q  <= data_in;
                        acc_max_q  <= data_in;
                        acc_cnt_q  <= CNT_WIDTH'(1);
                        sat_q      <= 1'b0;
                        mode_q     <= signed_mode;
                        error_q    <= 1'b0;
                        err_code_q <= ERR_NONE;
                    end else if (go && finish) begin
                        error_q <= 1'b1;
                        if (err_code_q == ERR_NONE) err_code_q <= ERR_GO_FIN;
                    end else if (finish) begin
                        error_q <= 1'b1;
                        if (err_code_q == ERR_NONE) err_code_q <= ERR_NO_GO;
                    end
                end
                RUN: begin
                    acc_min_q <= upd_min;
                    acc_max_q <= upd_max;
                    acc_cnt_q <= cnt_d;
                    sat_q     <= sat_d;
                    if (go) begin
                        error_q <= 1'b1;
                        if (err_code_q == ERR_NONE) err_code_q <= ERR_GO_RUN;
                    end
                    // The finishing cycle's sample is folded into the published results.
                    if (finish) begin
                        state_q     <= IDLE;
                        range_q     <= upd_max - upd_min;
                        min_q       <= upd_min;
                        max_q       <= upd_max;
                        count_q     <= cnt_d;
                        count_sat_q <= sat_d;
                        valid_q     <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign range     = range_q;
    assign min_out   = min_q;
    assign max_out   = max_q;
    assign count     = count_q;
    assign count_sat = count_sat_q;
    assign valid     = valid_q;
    assign busy      = (state_q == RUN);
    assign error     = error_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_range_finder_stats.sv
// Scoreboard bench for range_finder_stats (WIDTH=10, CNT_WIDTH=4).
module tb_range_finder_stats;

    localparam int unsigned W  = 10;
    localparam int unsigned CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [W-1:0]  data_in;
    logic          go, finish, signed_mode;
    logic [W-1:0]  range, min_out, max_out;
    logic [CW-1:0] count;
    logic          count_sat, valid, busy, error;
    logic [1:0]    err_code;

    typedef struct {
        logic [W-1:0]  rng;
        logic [W-1:0]  mn;
        logic [W-1:0]  mx;
        logic [CW-1:0] cnt;
        logic          sat;
    } exp_t;

    exp_t         sb[$];
    exp_t         got_e;
    logic [W-1:0] smp[$];
    int           total = 0;
    int           bad   = 0;

    range_finder_stats #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .data_in     (data_in),
        .go          (go),
        .finish      (finish),
        .signed_mode (signed_mode),
        .range       (range),
        .min_out     (min_out),
        .max_out     (max_out),
        .count       (count),
        .count_sat   (count_sat),
        .valid       (valid),
        .busy        (busy),
        .error       (error),
        .err_code    (err_code)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result monitor: every valid pulse must match the oldest pending expectation.
    always @(negedge clock) begin
        if (reset === 1'b0 && valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("valid_unexpected", 32'(valid), 32'(0));
            end else begin
                got_e = sb.pop_front();
                check("range",     32'(range),     32'(got_e.rng));
                check("min_out",   32'(min_out),   32'(got_e.mn));
                check("max_out",   32'(max_out),   32'(got_e.mx));
                check("count",     32'(count),     32'(got_e.cnt));
                check("count_sat", 32'(count_sat), 32'(got_e.sat));
            end
        end
    end

    task automatic step(input logic [W-1:0] d, input logic g, input logic f, input logic sm);
        @(negedge clock);
        data_in     = d;
        go          = g;
        finish      = f;
        signed_mode = sm;
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        data_in = '0;
        go      = 1'b0;
        finish  = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 6 && sb.size() != 0; i++) begin
            @(negedge clock);
            #1;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
    endtask

    // Drives smp as one burst and queues the expected result for it.
    task automatic run_burst(input logic sm);
        exp_t         e;
        logic [W-1:0] mn, mx;
        int           n = smp.size();
        mn = smp[0];
        mx = smp[0];
        for (int i = 1; i < n; i++) begin
            if (sm ? ($signed(smp[i]) < $signed(mn)) : (smp[i] < mn)) mn = smp[i];
            if (sm ? ($signed(smp[i]) > $signed(mx)) : (smp[i] > mx)) mx = smp[i];
        end
        e.rng = mx - mn;
        e.mn  = mn;
        e.mx  = mx;
        e.cnt = (n > (1 << CW) - 1) ? CW'((1 << CW) - 1) : CW'(n);
        e.sat = (n > (1 << CW) - 1);
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) sb.push_back(e);
            step(smp[i], i == 0, i == n - 1, sm);
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_range"},   32'(range),     32'(0));
        check({tag, "_min"},     32'(min_out),   32'(0));
        check({tag, "_max"},     32'(max_out),   32'(0));
        check({tag, "_count"},   32'(count),     32'(0));
        check({tag, "_sat"},     32'(count_sat), 32'(0));
        check({tag, "_valid"},   32'(valid),     32'(0));
        check({tag, "_busy"},    32'(busy),      32'(0));
        check({tag, "_error"},   32'(error),     32'(0));
        check({tag, "_errcode"}, 32'(err_code),  32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        signed_mode = 1'b0;
        idle();
        repeat (2) @(posedge clock);
        #1;
        chk_zero("rst");
        @(negedge clock);
        reset = 1'b0;

        // Basic unsigned burst.
        smp = '{10'd5, 10'd100, 10'd3, 10'd50};
        run_burst(1'b0);
        check("t1_busy_after", 32'(busy), 32'(0));
        drain();

        // Same data, signed then unsigned interpretation.
        smp = '{10'h200, 10'h1FF};
        run_burst(1'b1);
        drain();
        run_burst(1'b0);
        drain();

        // Protocol errors in IDLE leave results untouched.
        step(10'd0, 1'b0, 1'b1, 1'b0);
        check("noGo_error", 32'(error), 32'(1));
        check("noGo_code", 32'(err_code), 32'(1));
        check("noGo_range_held", 32'(range), 32'(1));
        step(10'd0, 1'b1, 1'b1, 1'b0);
        check("goFin_error", 32'(error), 32'(1));
        check("goFin_code_kept", 32'(err_code), 32'(1));
        step(10'd7, 1'b1, 1'b0, 1'b0);
        check("go_clr_error", 32'(error), 32'(0));
        check("go_clr_code", 32'(err_code), 32'(0));
        check("go_busy", 32'(busy), 32'(1));
        sb.push_back('{rng: 10'd0, mn: 10'd7, mx: 10'd7, cnt: 4'd2, sat: 1'b0});
        step(10'd7, 1'b0, 1'b1, 1'b0);
        drain();

        // go while running flags an error but the burst continues.
        step(10'd10, 1'b1, 1'b0, 1'b0);
        step(10'd20, 1'b1, 1'b0, 1'b0);
        check("goRun_error", 32'(error), 32'(1));
        check("goRun_code", 32'(err_code), 32'(2));
        check("goRun_busy", 32'(busy), 32'(1));
        sb.push_back('{rng: 10'd20, mn: 10'd10, mx: 10'd30, cnt: 4'd3, sat: 1'b0});
        step(10'd30, 1'b0, 1'b1, 1'b0);
        drain();
        check("goRun_error_kept", 32'(error), 32'(1));
        check("goRun_code_kept", 32'(err_code), 32'(2));

        // Counter saturation.
        smp.delete();
        for (int i = 0; i < 20; i++) smp.push_back(10'd7);
        run_burst(1'b0);
        drain();

        // Back-to-back bursts: second go lands on the valid cycle.
        smp = '{10'd1, 10'd9};
        run_burst(1'b0);
        check("b2b_valid", 32'(valid), 32'(1));
        smp = '{10'd4, 10'd2};
        run_burst(1'b0);
        drain();
        check("b2b_error", 32'(error), 32'(0));

        // Asynchronous reset mid-burst.
        step(10'd5, 1'b1, 1'b0, 1'b0);
        step(10'd6, 1'b0, 1'b0, 1'b0);
        check("mid_busy", 32'(busy), 32'(1));
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("rst_mid");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        step(10'd0, 1'b0, 1'b1, 1'b0);
        check("post_rst_error", 32'(error), 32'(1));
        check("post_rst_code", 32'(err_code), 32'(1));
        idle();
        step(10'd0, 1'b0, 1'b0, 1'b0);
        check("post_rst_novalid", 32'(valid), 32'(0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
